// File: rtl/rate_divided_hex_counter.sv
// Rate-divided 4-bit up/down digit counter with parallel load, for the 7-segment hex decoder.
// Optional HEX_COUNTER_BCD_EN: modulus 10 with load saturation to 9 (default build: modulus 16).
module rate_divided_hex_counter #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int DIV_W      = $clog2(4*CLOCK_FREQ)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] q,
  output logic       tick,
  output logic       wrap
);

`ifdef HEX_COUNTER_BCD_EN
  localparam logic [3:0] QMAX = 4'd9;
`else
  localparam logic [3:0] QMAX = 4'd15;
`endif

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       spd_q;
  logic [3:0]       step_q;
  logic             step_wrap;
  logic             speed_chg;
  logic             div_zero;

  function automatic logic [DIV_W-1:0] period_m1(input logic [1:0] s);
    logic [DIV_W-1:0] r;
    case (s)
      2'b00:   r = '0;
      2'b01:   r = DIV_W'(CLOCK_FREQ - 1);
      2'b10:   r = DIV_W'(2*CLOCK_FREQ - 1);
      default: r = DIV_W'(4*CLOCK_FREQ - 1);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] sat_load(input logic [3:0] v);
`ifdef HEX_COUNTER_BCD_EN
    return (v > QMAX) ? QMAX : v;
`else
    return v;
`endif
  endfunction

  // Step candidate: next digit value and whether it crosses the modulus boundary
  always_comb begin
    step_q    = q;
    step_wrap = 1'b0;
    if (dir) begin
      if (q >= QMAX) begin
        step_q    = 4'd0;
        step_wrap = 1'b1;
      end else begin
        step_q = q + 4'd1;
      end
    end else begin
      if (q == 4'd0) begin
        step_q    = QMAX;
        step_wrap = 1'b1;
      end else begin
        step_q = q - 4'd1;
      end
    end
  end

  assign speed_chg = (speed != spd_q);
  assign div_zero  = (div_cnt == '0);

  // Divider, stored speed and digit register; load beats speed change beats step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q       <= 4'd0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      spd_q   <= speed;
      div_cnt <= period_m1(speed);
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        q       <= sat_load(load_value);
        spd_q   <= speed;
        div_cnt <= period_m1(speed);
      end else if (speed_chg) begin
        spd_q   <= speed;
        div_cnt <= period_m1(speed);
      end else if (enable) begin
        if (div_zero) begin
          q       <= step_q;
          tick    <= 1'b1;
          wrap    <= step_wrap;
          div_cnt <= period_m1(spd_q);
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rate_divided_hex_counter.sv
// Scoreboard bench for rate_divided_hex_counter at CLOCK_FREQ=4.
module tb_rate_divided_hex_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] q;
  logic       tick;
  logic       wrap;

  typedef struct {
    logic [3:0] q;
    logic       tick;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   npass = 0;
  int   ntotal = 0;

  rate_divided_hex_counter #(.CLOCK_FREQ(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .speed(speed), .dir(dir),
    .load(load), .load_value(load_value), .q(q), .tick(tick), .wrap(wrap)
  );

  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse between edges; caller sets speed first
  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    speed = 2'b00; enable = 1'b0; load = 1'b0; dir = 1'b1;
    reset = 1'b1;
    #2;
    sbq.push_back('{q: 4'd0, tick: 1'b0, wrap: 1'b0});
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL reset: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_full_rate();
    speed = 2'b00; dir = 1'b1; enable = 1'b0; load = 1'b0;
    pulse_reset();
    enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      sbq.push_back('{q: 4'(i % 16), tick: 1'b1, wrap: (i % 16 == 0)});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL full_rate edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
  endtask

  task automatic test_1hz();
    enable = 1'b0; speed = 2'b01; dir = 1'b1;
    pulse_reset();
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      sbq.push_back('{q: (i >= 8) ? 4'd2 : (i >= 4) ? 4'd1 : 4'd0,
                      tick: (i == 4 || i == 8), wrap: 1'b0});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL 1hz edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
  endtask

  task automatic test_down_load();
    // load edge coincides with a speed change: load wins, divider uses the new speed
    load = 1'b1; load_value = 4'd2; speed = 2'b00; dir = 1'b0;
    sbq.push_back('{q: 4'd2, tick: 1'b0, wrap: 1'b0});
    cycle();
    load = 1'b0;
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL load2: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    for (int i = 1; i <= 3; i++) begin
      sbq.push_back('{q: (i == 1) ? 4'd1 : (i == 2) ? 4'd0 : 4'd15, tick: 1'b1, wrap: (i == 3)});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL down edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
    // load over a coincident step (full rate, enabled)
    load = 1'b1; load_value = 4'd9;
    sbq.push_back('{q: 4'd9, tick: 1'b0, wrap: 1'b0});
    cycle();
    load = 1'b0;
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL load_over_step: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    sbq.push_back('{q: 4'd8, tick: 1'b1, wrap: 1'b0});
    cycle();
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL after_load_step: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    // load while disabled
    enable = 1'b0; load = 1'b1; load_value = 4'd5;
    sbq.push_back('{q: 4'd5, tick: 1'b0, wrap: 1'b0});
    cycle();
    load = 1'b0;
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL load_disabled: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
  endtask

  task automatic test_enable_speed();
    enable = 1'b0; speed = 2'b11; dir = 1'b1; load = 1'b0;
    pulse_reset();
    // 10 enabled, 5 disabled, 6 enabled: step lands on the 16th enabled edge
    for (int i = 1; i <= 21; i++) begin
      enable = !(i >= 11 && i <= 15);
      sbq.push_back('{q: (i == 21) ? 4'd1 : 4'd0, tick: (i == 21), wrap: 1'b0});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL enable_hold edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      sbq.push_back('{q: 4'd1, tick: 1'b0, wrap: 1'b0});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL mid_period edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
    // change edge (index 0), then 8 enabled edges; dir flips mid-period
    speed = 2'b10;
    for (int i = 0; i <= 8; i++) begin
      if (i == 4) dir = 1'b0;
      sbq.push_back('{q: (i == 8) ? 4'd0 : 4'd1, tick: (i == 8), wrap: 1'b0});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL speed_change edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
  endtask

  task automatic test_async_reset();
    speed = 2'b00; dir = 1'b1; enable = 1'b1; load = 1'b1; load_value = 4'd6;
    cycle();
    load = 1'b0;
    sbq.push_back('{q: 4'd7, tick: 1'b1, wrap: 1'b0});
    cycle();
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL pre_reset: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    #2;
    speed = 2'b01;
    reset = 1'b1;
    #1;
    sbq.push_back('{q: 4'd0, tick: 1'b0, wrap: 1'b0});
    e = sbq.pop_front();
    ntotal++;
    if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
      $display("FAIL async_reset: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", q, tick, wrap, e.q, e.tick, e.wrap);
    else npass++;
    #2;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sbq.push_back('{q: (i == 4) ? 4'd1 : 4'd0, tick: (i == 4), wrap: 1'b0});
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL post_reset edge %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
  endtask

  task automatic test_modulus();
    speed = 2'b00; dir = 1'b1; enable = 1'b1;
`ifdef HEX_COUNTER_BCD_EN
    load = 1'b1; load_value = 4'd8;
    sbq.push_back('{q: 4'd8, tick: 1'b0, wrap: 1'b0});
    sbq.push_back('{q: 4'd9, tick: 1'b1, wrap: 1'b0});
    sbq.push_back('{q: 4'd0, tick: 1'b1, wrap: 1'b1});
    sbq.push_back('{q: 4'd9, tick: 1'b0, wrap: 1'b0});
    for (int i = 0; i < 4; i++) begin
      load = (i == 0 || i == 3);
      load_value = (i == 3) ? 4'd12 : 4'd8;
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL bcd step %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
`else
    sbq.push_back('{q: 4'd12, tick: 1'b0, wrap: 1'b0});
    sbq.push_back('{q: 4'd13, tick: 1'b1, wrap: 1'b0});
    for (int i = 0; i < 2; i++) begin
      load = (i == 0);
      load_value = 4'd12;
      cycle();
      e = sbq.pop_front();
      ntotal++;
      if ({q, tick, wrap} !== {e.q, e.tick, e.wrap})
        $display("FAIL hex_load step %0d: got q=%0d tick=%b wrap=%b, want q=%0d tick=%b wrap=%b", i, q, tick, wrap, e.q, e.tick, e.wrap);
      else npass++;
    end
`endif
    load = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_full_rate();
    test_1hz();
    test_down_load();
    test_enable_speed();
    test_async_reset();
    test_modulus();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/rate_divided_hex_counter.md
Name: rate_divided_hex_counter

Overview:
Timed 4-bit digit source that feeds the team's 7-segment hex decoder stage. Its q output drives the decoder's 4-bit digit input directly.
- A programmable rate divider generates a count-enable pulse.
- An up/down digit counter with synchronous parallel load advances on each pulse.
- Used on the board to show a visibly stepping digit at 1 Hz, 0.5 Hz or 0.25 Hz, or at full clock rate for simulation.

Parameters:
CLOCK_FREQ, 50000000, clock cycles per second; sets the divider period. Benches use 4.
DIV_W, $clog2(4*CLOCK_FREQ), width of the divider down-counter. Derived; do not override.

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = divider and counter run; 0 = everything holds
speed  input  2  00 full rate, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz
dir  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_value  input  4  value loaded into q
q  output  4  current digit, to hex decoder input
tick  output  1  registered; high for exactly one cycle after each count step
wrap  output  1  registered; high for exactly one cycle after a step that wrapped

Behaviour:
- Reset (async, active-high, any time including mid-count):
  - q=0, tick=0, wrap=0.
  - Divider = N(speed)-1.
  - Stored speed = current speed input.
- Period N(speed): 00→1, 01→CLOCK_FREQ, 10→2*CLOCK_FREQ, 11→4*CLOCK_FREQ.
- Divider: down-counter, decrements only on edges with enable=1.
  - At an enabled edge where divider==0: reload to N-1, perform one count step on that same edge, register tick=1 for the following cycle.
  - Speed 00: divider is permanently 0, so a step occurs on every enabled edge.
- Latency: the first step after reset or reload occurs on the N-th enabled edge. New q and tick=1 become visible together after that edge.
- Count step:
  - dir=1: q+1, with 15→0.
  - dir=0: q-1, with 0→15.
  - wrap=1 for the cycle after a wrapping step; otherwise 0.
- enable=0: divider, q and stored speed hold; tick=0 and wrap=0 next cycle. No catch-up step on re-enable.
- load=1 on an edge, regardless of enable:
  - q ← load_value; divider ← N(speed)-1.
  - tick=0, wrap=0 next cycle.
  - Load has priority over a coincident step; the step is discarded, not deferred.
- Speed change: when the speed input differs from the stored speed on an edge, regardless of enable:
  - Divider ← N(new)-1; stored speed updated.
  - No step that edge, even if divider==0.
  - If load occurs on the same edge, the load rule applies and the divider uses N(new).
- dir is sampled only on the stepping edge. Changing dir mid-period never resets the divider.
- tick and wrap are never high for two consecutive cycles unless speed=00 with enable held high. At 00, tick stays high continuously.
- No combinational path from any input to q, tick or wrap.

Optional Feature:
Macro: HEX_COUNTER_BCD_EN
- Defined: counter modulus 10 for decimal display.
  - Up: 9→0 wraps. Down: 0→9 wraps; wrap rules unchanged.
  - load_value >9 saturates to q=9.
- Undefined: modulus 16 as specified above; any load_value is accepted.

Test Plan:
All scenarios use CLOCK_FREQ=4.
- Full-rate up-count: reset, speed=00, dir=1, enable=1 for 17 edges → q steps 1,2,…,15,0,1; tick=1 continuously; wrap=1 only in the cycle after q becomes 0.
- 1 Hz timing: speed=01, enable=1 → q=1 after edge 4 and q=2 after edge 8; tick=1 only in the cycles after edges 4 and 8.
- Down-count and load: load=1 with load_value=2; then dir=0, speed=00, 3 edges → q=1,0,15; wrap pulses after the step to 15. A load coinciding with a step → q=load_value, tick=0.
- Enable hold and speed change: speed=11, enable=1 for 10 edges, enable=0 for 5 edges → q=0 still. Re-enable; step after edge 16 counted from start of enabled operation. Then switch to speed=10 mid-period → next step exactly 8 enabled edges after the change.
- Async reset: assert reset between clock edges with q=7 → q=0, tick=0, wrap=0 immediately, before the next edge. Release → first step after N enabled edges.
- BCD (HEX_COUNTER_BCD_EN defined): up-count from 8 → 9,0 with wrap after 0; load_value=12 → q=9.
